// File: rtl/seq_unit_if.sv
// Controller-facing bundle for seq_unit: run/step gating, the instruction
// byte, the jump target, the carry input, the micro-strobes, and the state
// returned to the controller.
interface seq_unit_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);

  logic             run;
  logic             step;
  logic [7:0]       ram_q;
  logic [PC_W-1:0]  bus;
  logic             cy_in;
  logic             sm_en;
  logic             ld_ir;
  logic             in_pc;
  logic             ld_pc;
  logic             g_en;

  logic             sm;
  logic [7:0]       ir;
  logic [PC_W-1:0]  pc;
  logic             gf;
  logic             adv;
  logic             halted;
  logic [CNT_W-1:0] icount;

  // Controller side: drives gating and strobes, observes sequencer state
  modport master (
    output run, step, ram_q, bus, cy_in, sm_en, ld_ir, in_pc, ld_pc, g_en,
    input  sm, ir, pc, gf, adv, halted, icount
  );

  // Sequencer side: applies strobes, returns state
  modport slave (
    input  run, step, ram_q, bus, cy_in, sm_en, ld_ir, in_pc, ld_pc, g_en,
    output sm, ir, pc, gf, adv, halted, icount
  );

endinterface

// File: rtl/seq_unit.sv
// Sequencer state for the microcoded controller: fetch/execute phase bit,
// instruction register, program counter and condition flag. The controller's
// strobes only take effect on cycles where adv is high, which is set by
// free-run or by a single-step rising edge, and is forced low once a halt
// opcode has been executed. A saturating counter tracks retired instructions.
module seq_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit              HALT_EN  = 1'b1,
  parameter logic [3:0]      HALT_OP  = 4'hF,
  parameter int              CNT_W    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_unit_if.slave sif
);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [7:0]       ir_q, ir_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             gf_q, gf_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             step_q;

  logic             adv;
  logic             step_rise;
  logic             retire;
  logic             halt_hit;

  // Advance gate: free-run level or a fresh step edge, never once halted
  always_comb begin
    step_rise = sif.step & ~step_q;
    adv       = ~halted_q & (sif.run | step_rise);
  end

  // Retire and halt decode, both keyed off being in the execute phase
  always_comb begin
    retire   = (phase_q == PH_EXEC) & sif.sm_en;
    halt_hit = HALT_EN & (phase_q == PH_EXEC) & (ir_q[7:4] == HALT_OP);
  end

  // Phase next-state: toggles between fetch and execute on sm_en
  always_comb begin
    phase_d = phase_q;
    if (adv && sif.sm_en) begin
      case (phase_q)
        PH_FETCH: phase_d = PH_EXEC;
        PH_EXEC:  phase_d = PH_FETCH;
        default:  phase_d = PH_FETCH;
      endcase
    end
  end

  // Datapath next-state: ir load, pc jump/increment, flag capture
  always_comb begin
    ir_d = ir_q;
    pc_d = pc_q;
    gf_d = gf_q;
    if (adv) begin
      if (sif.ld_ir) begin
        ir_d = sif.ram_q;
      end
      if (sif.ld_pc) begin
        pc_d = sif.bus;
      end else if (sif.in_pc) begin
        pc_d = pc_q + PC_W'(1);
      end
      if (sif.g_en) begin
        gf_d = sif.cy_in;
      end
    end
  end

  // Retired-instruction counter, holding at all-ones
  always_comb begin
    icount_d = icount_q;
    if (adv && retire && (icount_q != {CNT_W{1'b1}})) begin
      icount_d = icount_q + CNT_W'(1);
    end
  end

  // Sticky halt: set on an advancing cycle that executes the halt opcode
  always_comb begin
    halted_d = halted_q;
    if (adv && halt_hit) begin
      halted_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= PH_FETCH;
      ir_q     <= 8'h00;
      pc_q     <= RESET_PC;
      gf_q     <= 1'b0;
      halted_q <= 1'b0;
      icount_q <= '0;
      step_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      gf_q     <= gf_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
      step_q   <= sif.step;
    end
  end

  // Register outputs back to the controller
  always_comb begin
    sif.sm     = (phase_q == PH_EXEC);
    sif.ir     = ir_q;
    sif.pc     = pc_q;
    sif.gf     = gf_q;
    sif.halted = halted_q;
    sif.icount = icount_q;
    sif.adv    = adv;
  end

endmodule

// File: tb/tb_seq_unit.sv
// Self-checking bench for seq_unit: directed scenarios for reset, fetch and
// execute, jump priority, single-step, halt and flag handling, followed by
// randomized strobes compared against a behavioural model of the sequencer.
module tb_seq_unit;

  localparam int              PC_W     = 8;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;
  localparam bit              HALT_EN  = 1'b1;
  localparam logic [3:0]      HALT_OP  = 4'hF;
  localparam int              CNT_W    = 4;
  localparam int              PC_MOD   = 1 << PC_W;
  localparam int              CNT_MAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  // Behavioural model state
  int mSm;
  int mIr;
  int mPc;
  int mGf;
  int mHalted;
  int mIcount;
  int mStepPrev;

  seq_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) sif ();

  seq_unit #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC),
    .HALT_EN (HALT_EN),
    .HALT_OP (HALT_OP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clearInputs();
    sif.run   = 1'b0;
    sif.step  = 1'b0;
    sif.ram_q = 8'h00;
    sif.bus   = '0;
    sif.cy_in = 1'b0;
    sif.sm_en = 1'b0;
    sif.ld_ir = 1'b0;
    sif.in_pc = 1'b0;
    sif.ld_pc = 1'b0;
    sif.g_en  = 1'b0;
  endtask

  function automatic int modelAdv();
    if (mHalted != 0) return 0;
    if (sif.run) return 1;
    if (sif.step && mStepPrev == 0) return 1;
    return 0;
  endfunction

  // Model update for one rising edge, using the inputs currently applied
  task automatic modelEdge(input logic rstVal);
    int a;
    int oldSm;
    int oldIr;
    if (!rstVal) begin
      mSm = 0; mIr = 0; mPc = int'(RESET_PC); mGf = 0;
      mHalted = 0; mIcount = 0; mStepPrev = 0;
      return;
    end
    a = modelAdv();
    oldSm = mSm;
    oldIr = mIr;
    if (a != 0) begin
      if (sif.sm_en) mSm = 1 - oldSm;
      if (sif.ld_ir) mIr = int'(sif.ram_q);
      if (sif.ld_pc) mPc = int'(sif.bus);
      else if (sif.in_pc) mPc = (mPc + 1) % PC_MOD;
      if (sif.g_en) mGf = int'(sif.cy_in);
      if (oldSm == 1 && sif.sm_en && mIcount < CNT_MAX) mIcount = mIcount + 1;
      if (HALT_EN && oldSm == 1 && (oldIr / 16) == int'(HALT_OP)) mHalted = 1;
    end
    mStepPrev = int'(sif.step);
  endtask

  // Applies the currently set inputs for one clock and checks all outputs
  task automatic applyStimulus(input logic rstVal);
    rst_n = rstVal;
    #1;
    checkOutput("adv", 32'(sif.adv), 32'(modelAdv()));
    @(posedge clk);
    modelEdge(rstVal);
    #1;
    checkOutput("sm",     32'(sif.sm),     32'(mSm));
    checkOutput("ir",     32'(sif.ir),     32'(mIr));
    checkOutput("pc",     32'(sif.pc),     32'(mPc));
    checkOutput("gf",     32'(sif.gf),     32'(mGf));
    checkOutput("halted", 32'(sif.halted), 32'(mHalted));
    checkOutput("icount", 32'(sif.icount), 32'(mIcount));
  endtask

  initial begin
    logic [7:0] savedPc;
    logic [7:0] savedIr;
    logic       savedSm;
    int         haltAge;
    vectors     = 0;
    miscompares = 0;
    mSm = 0; mIr = 0; mPc = 0; mGf = 0; mHalted = 0; mIcount = 0; mStepPrev = 0;
    rst_n = 1'b0;
    clearInputs();

    // T1: reset held two cycles with run high
    sif.run = 1'b1;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("T1 sm", 32'(sif.sm), 32'h0);
    checkOutput("T1 ir", 32'(sif.ir), 32'h00);
    checkOutput("T1 pc", 32'(sif.pc), 32'(RESET_PC));
    checkOutput("T1 gf", 32'(sif.gf), 32'h0);
    checkOutput("T1 halted", 32'(sif.halted), 32'h0);
    checkOutput("T1 icount", 32'(sif.icount), 32'h0);

    // T2: fetch then execute
    clearInputs();
    sif.run = 1'b1; sif.sm_en = 1'b1; sif.ld_ir = 1'b1; sif.in_pc = 1'b1; sif.ram_q = 8'h35;
    applyStimulus(1'b1);
    checkOutput("T2 ir", 32'(sif.ir), 32'h35);
    checkOutput("T2 pc", 32'(sif.pc), 32'h01);
    checkOutput("T2 sm1", 32'(sif.sm), 32'h1);
    clearInputs();
    sif.run = 1'b1; sif.sm_en = 1'b1;
    applyStimulus(1'b1);
    checkOutput("T2 sm0", 32'(sif.sm), 32'h0);
    checkOutput("T2 icount", 32'(sif.icount), 32'h1);

    // T3: jump has priority over increment, increment wraps
    clearInputs();
    sif.run = 1'b1; sif.ld_pc = 1'b1; sif.bus = 8'h10;
    applyStimulus(1'b1);
    sif.in_pc = 1'b1; sif.bus = 8'h80;
    applyStimulus(1'b1);
    checkOutput("T3 jump", 32'(sif.pc), 32'h80);
    sif.in_pc = 1'b0; sif.bus = 8'hFF;
    applyStimulus(1'b1);
    sif.ld_pc = 1'b0; sif.in_pc = 1'b1; sif.bus = 8'h55;
    applyStimulus(1'b1);
    checkOutput("T3 wrap", 32'(sif.pc), 32'h00);

    // T4: held step advances once, a fresh edge advances again
    clearInputs();
    sif.in_pc = 1'b1;
    applyStimulus(1'b1);
    savedPc = sif.pc;
    sif.step = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    checkOutput("T4 held", 32'(sif.pc), 32'(savedPc + 8'd1));
    sif.step = 1'b0;
    applyStimulus(1'b1);
    sif.step = 1'b1;
    applyStimulus(1'b1);
    checkOutput("T4 reedge", 32'(sif.pc), 32'(savedPc + 8'd2));

    // T5: halt opcode stops the machine until reset
    clearInputs();
    applyStimulus(1'b0);
    sif.run = 1'b1; sif.sm_en = 1'b1; sif.ld_ir = 1'b1; sif.ram_q = 8'hF0;
    applyStimulus(1'b1);
    sif.ld_ir = 1'b0;
    applyStimulus(1'b1);
    checkOutput("T5 halted", 32'(sif.halted), 32'h1);
    checkOutput("T5 icount", 32'(sif.icount), 32'h1);
    savedPc = sif.pc; savedIr = sif.ir; savedSm = sif.sm;
    sif.in_pc = 1'b1; sif.ld_ir = 1'b1; sif.ram_q = 8'h12;
    for (int i = 0; i < 10; i++) begin
      sif.step = ~sif.step;
      applyStimulus(1'b1);
    end
    checkOutput("T5 pc frozen", 32'(sif.pc), 32'(savedPc));
    checkOutput("T5 ir frozen", 32'(sif.ir), 32'(savedIr));
    checkOutput("T5 sm frozen", 32'(sif.sm), 32'(savedSm));
    applyStimulus(1'b0);
    checkOutput("T5 cleared", 32'(sif.halted), 32'h0);

    // T6: flag capture, then reset beats a same-cycle load
    clearInputs();
    sif.run = 1'b1; sif.g_en = 1'b1; sif.cy_in = 1'b1;
    applyStimulus(1'b1);
    checkOutput("T6 gf", 32'(sif.gf), 32'h1);
    sif.g_en = 1'b0; sif.ld_ir = 1'b1; sif.ram_q = 8'hAA;
    applyStimulus(1'b0);
    checkOutput("T6 ir", 32'(sif.ir), 32'h00);
    checkOutput("T6 gf0", 32'(sif.gf), 32'h0);

    // Randomized strobes against the model
    haltAge = 0;
    for (int i = 0; i < 2000; i++) begin
      logic rstVal;
      sif.run   = ($urandom_range(0, 2) == 0);
      sif.step  = 1'($urandom);
      sif.ram_q = 8'($urandom);
      sif.bus   = PC_W'($urandom);
      sif.cy_in = 1'($urandom);
      sif.sm_en = ($urandom_range(0, 3) != 0);
      sif.ld_ir = 1'($urandom);
      sif.in_pc = 1'($urandom);
      sif.ld_pc = ($urandom_range(0, 4) == 0);
      sif.g_en  = 1'($urandom);
      haltAge = (mHalted != 0) ? haltAge + 1 : 0;
      rstVal = !(($urandom_range(0, 79) == 0) || haltAge > 6);
      applyStimulus(rstVal);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
